// File: rtl/gc_track_decoder_if.sv
// Position bus between a Gray position source and gc_track_decoder.
// master drives the Gray word and clear strobe; slave returns decode and tracking status.
interface gc_track_decoder_if #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned POS_WIDTH = 16
);
   logic [WIDTH-1:0]     Gc_input;
   logic                 clr_pos;
   logic [WIDTH-1:0]     Bin_output;
   logic [POS_WIDTH-1:0] pos;
   logic                 step_valid;
   logic                 dir;
   logic                 err;
   logic [7:0]           err_count;

   modport master (
      output Gc_input, clr_pos,
      input  Bin_output, pos, step_valid, dir, err, err_count
   );

   modport slave (
      input  Gc_input, clr_pos,
      output Bin_output, pos, step_valid, dir, err, err_count
   );
endinterface

// File: rtl/gc_track_decoder.sv
// Synchronizes an asynchronous Gray position word, decodes it to binary and
// accumulates single-bit steps into a signed position; multi-bit jumps are flagged.
module gc_track_decoder #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned POS_WIDTH   = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic               clk,
   input logic               rst,
   gc_track_decoder_if.slave bus
);

   localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

   typedef enum logic {
      FILL,
      TRACK
   } state_e;

   state_e               state_q;
   logic [FILL_W-1:0]    fill_q;
   logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]     gs_prev_q;
   logic [WIDTH-1:0]     bin_q;
   logic [POS_WIDTH-1:0] pos_q;
   logic                 step_valid_q;
   logic                 dir_q;
   logic                 err_q;
   logic [7:0]           err_count_q;

   logic [WIDTH-1:0]     gs;
   logic [WIDTH-1:0]     diff_d;
   logic [WIDTH-1:0]     b_new_d;
   logic [WIDTH-1:0]     b_old_d;
   logic                 single_d;
   logic                 multi_d;
   logic                 up_d;

   // Binary bit i is the XOR of all Gray bits at or above i.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   assign gs = sync_q[SYNC_STAGES-1];

   // Transition classification against the previous synchronized word.
   always_comb begin
      diff_d   = gs ^ gs_prev_q;
      b_new_d  = gray2bin(gs);
      b_old_d  = gray2bin(gs_prev_q);
      single_d = (diff_d != '0) && ((diff_d & (diff_d - WIDTH'(1))) == '0);
      multi_d  = (diff_d != '0) && !single_d;
      up_d     = ((b_new_d - b_old_d) == WIDTH'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         state_q      <= FILL;
         fill_q       <= '0;
         gs_prev_q    <= '0;
         bin_q        <= '0;
         pos_q        <= '0;
         step_valid_q <= 1'b0;
         dir_q        <= 1'b0;
         err_q        <= 1'b0;
         err_count_q  <= '0;
      end else begin
         sync_q[0] <= bus.Gc_input;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         gs_prev_q    <= gs;
         bin_q        <= b_new_d;
         step_valid_q <= 1'b0;
         err_q        <= 1'b0;

         case (state_q)
            // Hold off tracking until the chain and gs_prev both carry the live input.
            FILL: begin
               if (fill_q == FILL_W'(SYNC_STAGES)) begin
                  state_q <= TRACK;
               end else begin
                  fill_q <= fill_q + FILL_W'(1);
               end
            end
            TRACK: begin
               if (single_d) begin
                  step_valid_q <= 1'b1;
                  dir_q        <= up_d;
                  pos_q        <= up_d ? (pos_q + POS_WIDTH'(1)) : (pos_q - POS_WIDTH'(1));
               end else if (multi_d) begin
                  err_q <= 1'b1;
                  if (err_count_q != 8'hFF) begin
                     err_count_q <= err_count_q + 8'd1;
                  end
               end
            end
            default: state_q <= FILL;
         endcase

         if (bus.clr_pos) begin
            pos_q <= '0;
         end
      end
   end

   assign bus.Bin_output = bin_q;
   assign bus.pos        = pos_q;
   assign bus.step_valid = step_valid_q;
   assign bus.dir        = dir_q;
   assign bus.err        = err_q;
   assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_gc_track_decoder.sv
// Directed bench for gc_track_decoder: reset fill, up/down steps, wrap,
// illegal jumps, clr_pos priority, err_count saturation and mid-run reset.
module tb_gc_track_decoder;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   gc_track_decoder_if bus ();

   gc_track_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] gray(input int unsigned b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] g);
      rst          = 1'b1;
      bus.Gc_input = g;
      bus.clr_pos  = 1'b0;
      tick();
      rst = 1'b0;
      repeat (6) tick();
   endtask

   task automatic up_steps(input int unsigned from, input int unsigned count);
      for (int unsigned i = from + 1; i <= from + count; i++) begin
         bus.Gc_input = gray(i % 16);
         repeat (4) tick();
      end
   endtask

   task automatic test_reset();
      int pulses;
      rst          = 1'b1;
      bus.Gc_input = 4'b0110;
      bus.clr_pos  = 1'b0;
      tick();
      n_cmp++;
      if ({bus.Bin_output, bus.pos, bus.step_valid, bus.dir, bus.err, bus.err_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got bin=%h pos=%h sv=%b dir=%b err=%b ec=%0d required all 0",
                  bus.Bin_output, bus.pos, bus.step_valid, bus.dir, bus.err, bus.err_count);
      end
      rst    = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (bus.step_valid || bus.err) pulses++;
         if (i == 3) begin
            n_cmp++;
            if (bus.Bin_output !== 4'b0100) begin
               n_fail++;
               $display("FAIL reset_fill_bin: got %b required 0100", bus.Bin_output);
            end
         end
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL reset_fill_pulses: got %0d required 0", pulses);
      end
      n_cmp++;
      if (bus.pos !== 16'h0000 || bus.err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_fill_counts: got pos=%h ec=%0d required 0/0", bus.pos, bus.err_count);
      end
   endtask

   task automatic test_up_sweep();
      int pulses;
      int bad_dir;
      do_reset(4'b0000);
      pulses  = 0;
      bad_dir = 0;
      for (int unsigned i = 1; i <= 16; i++) begin
         bus.Gc_input = gray(i % 16);
         repeat (4) begin
            tick();
            if (bus.step_valid) begin
               pulses++;
               if (bus.dir !== 1'b1) bad_dir++;
            end
         end
         n_cmp++;
         if (bus.Bin_output !== 4'(i % 16)) begin
            n_fail++;
            $display("FAIL up_sweep_bin[%0d]: got %h required %h", i, bus.Bin_output, 4'(i % 16));
         end
      end
      n_cmp++;
      if (pulses !== 16 || bad_dir !== 0) begin
         n_fail++;
         $display("FAIL up_sweep_pulses: got %0d pulses %0d bad dir required 16/0", pulses, bad_dir);
      end
      n_cmp++;
      if (bus.pos !== 16'h0010) begin
         n_fail++;
         $display("FAIL up_sweep_pos: got %h required 0010", bus.pos);
      end
   endtask

   task automatic test_down_step();
      do_reset(4'b0000);
      bus.Gc_input = 4'b1000;
      repeat (3) tick();
      n_cmp++;
      if (bus.step_valid !== 1'b1 || bus.dir !== 1'b0) begin
         n_fail++;
         $display("FAIL down_pulse: got sv=%b dir=%b required 1/0", bus.step_valid, bus.dir);
      end
      tick();
      n_cmp++;
      if (bus.Bin_output !== 4'hF || bus.pos !== 16'hFFFF || bus.step_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL down_result: got bin=%h pos=%h sv=%b required F/FFFF/0",
                  bus.Bin_output, bus.pos, bus.step_valid);
      end
   endtask

   task automatic test_illegal();
      do_reset(4'b0000);
      bus.Gc_input = 4'b0011;
      repeat (3) tick();
      n_cmp++;
      if (bus.err !== 1'b1 || bus.step_valid !== 1'b0 || bus.err_count !== 8'd1) begin
         n_fail++;
         $display("FAIL illegal_pulse: got err=%b sv=%b ec=%0d required 1/0/1",
                  bus.err, bus.step_valid, bus.err_count);
      end
      n_cmp++;
      if (bus.pos !== 16'h0000 || bus.Bin_output !== 4'b0010) begin
         n_fail++;
         $display("FAIL illegal_state: got pos=%h bin=%b required 0000/0010", bus.pos, bus.Bin_output);
      end
      tick();
      n_cmp++;
      if (bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_one_cycle: got err=%b required 0", bus.err);
      end
      bus.Gc_input = 4'b0010;
      repeat (3) tick();
      n_cmp++;
      if (bus.step_valid !== 1'b1 || bus.dir !== 1'b1 || bus.pos !== 16'h0001) begin
         n_fail++;
         $display("FAIL illegal_resync: got sv=%b dir=%b pos=%h required 1/1/0001",
                  bus.step_valid, bus.dir, bus.pos);
      end
   endtask

   task automatic test_clr_and_saturate();
      do_reset(4'b0000);
      up_steps(0, 5);
      n_cmp++;
      if (bus.pos !== 16'h0005) begin
         n_fail++;
         $display("FAIL clr_setup_pos: got %h required 0005", bus.pos);
      end
      bus.Gc_input = gray(6);
      repeat (2) tick();
      bus.clr_pos = 1'b1;
      tick();
      bus.clr_pos = 1'b0;
      n_cmp++;
      if (bus.pos !== 16'h0000 || bus.step_valid !== 1'b1 || bus.dir !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_priority: got pos=%h sv=%b dir=%b required 0000/1/1",
                  bus.pos, bus.step_valid, bus.dir);
      end
      for (int i = 0; i < 300; i++) begin
         bus.Gc_input = ~bus.Gc_input;
         tick();
      end
      repeat (4) tick();
      n_cmp++;
      if (bus.err_count !== 8'd255) begin
         n_fail++;
         $display("FAIL err_saturate: got %0d required 255", bus.err_count);
      end
      n_cmp++;
      if (bus.pos !== 16'h0000 || bus.dir !== 1'b1) begin
         n_fail++;
         $display("FAIL err_holds_pos_dir: got pos=%h dir=%b required 0000/1", bus.pos, bus.dir);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      do_reset(4'b0000);
      up_steps(0, 5);
      bus.Gc_input = 4'b1000;
      tick();
      bus.Gc_input = gray(5);
      tick();
      bus.Gc_input = 4'b1000;
      repeat (4) tick();
      n_cmp++;
      if (bus.pos !== 16'h0005 || bus.err_count !== 8'd3) begin
         n_fail++;
         $display("FAIL mid_setup: got pos=%h ec=%0d required 0005/3", bus.pos, bus.err_count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({bus.Bin_output, bus.pos, bus.step_valid, bus.dir, bus.err, bus.err_count} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_state: got bin=%h pos=%h sv=%b dir=%b err=%b ec=%0d required all 0",
                  bus.Bin_output, bus.pos, bus.step_valid, bus.dir, bus.err, bus.err_count);
      end
      pulses = 0;
      repeat (6) begin
         tick();
         if (bus.step_valid || bus.err) pulses++;
      end
      n_cmp++;
      if (pulses !== 0 || bus.Bin_output !== 4'hF || bus.pos !== 16'h0000) begin
         n_fail++;
         $display("FAIL mid_fill: got pulses=%0d bin=%h pos=%h required 0/F/0000",
                  pulses, bus.Bin_output, bus.pos);
      end
      bus.Gc_input = 4'b0000;
      repeat (3) tick();
      n_cmp++;
      if (bus.step_valid !== 1'b1 || bus.dir !== 1'b1 || bus.pos !== 16'h0001 || bus.Bin_output !== 4'h0) begin
         n_fail++;
         $display("FAIL mid_resume: got sv=%b dir=%b pos=%h bin=%h required 1/1/0001/0",
                  bus.step_valid, bus.dir, bus.pos, bus.Bin_output);
      end
   endtask

   initial begin
      n_cmp        = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.Gc_input = 4'b0000;
      bus.clr_pos  = 1'b0;
      test_reset();
      test_up_sweep();
      test_down_step();
      test_illegal();
      test_clr_and_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
